// File: rtl/lt24_bus_decoder.sv
// Decodes a sampled LT24 (ILI9341-style) parallel bus into command pulses and
// pixel writes with window-aware X/Y coordinates.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | after reset or LT24Reset_n low; data writes are dropped
// COL_ARGS  | collecting 4 column-address bytes (cmd 0x2A)
// PAGE_ARGS | collecting 4 page-address bytes (cmd 0x2B)
// MEM_WRITE | each data write is a pixel at the cursor (cmd 0x2C)
// IGNORE    | unknown command or argument set complete; data dropped
module lt24_bus_decoder #(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 320
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        LT24Wr_n,
   input  logic        LT24Rd_n,
   input  logic        LT24CS_n,
   input  logic        LT24RS,
   input  logic        LT24Reset_n,
   input  logic        LT24LCDOn,
   input  logic [15:0] LT24Data,
   output logic        cmdValid,
   output logic [7:0]  cmdCode,
   output logic        pixelValid,
   output logic [7:0]  pixelX,
   output logic [8:0]  pixelY,
   output logic [15:0] pixelData,
   output logic        frameDone,
   output logic        lcdOn
);

   typedef enum logic [2:0] {IDLE, COL_ARGS, PAGE_ARGS, MEM_WRITE, IGNORE} state_t;

   typedef struct packed {
      logic        wr_n;
      logic        rd_n;
      logic        cs_n;
      logic        rs;
      logic        reset_n;
      logic        lcd_on;
      logic [15:0] data;
   } bus_t;

   localparam bus_t BUS_RST = '{wr_n: 1'b1, rd_n: 1'b1, cs_n: 1'b1, rs: 1'b0,
                                reset_n: 1'b0, lcd_on: 1'b0, data: 16'h0000};
   localparam logic [7:0]  X_MAX   = 8'(WIDTH - 1);
   localparam logic [8:0]  Y_MAX   = 9'(HEIGHT - 1);
   localparam logic [15:0] X_LIM16 = 16'(WIDTH - 1);
   localparam logic [15:0] Y_LIM16 = 16'(HEIGHT - 1);

   state_t      state_q, state_d;
   bus_t        bus_r1_q, bus_r1_d, bus_r2_q, bus_r2_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  start_hi_q, start_hi_d, start_lo_q, start_lo_d, end_hi_q, end_hi_d;
   logic [7:0]  x_start_q, x_start_d, x_end_q, x_end_d, x_q, x_d;
   logic [8:0]  y_start_q, y_start_d, y_end_q, y_end_d, y_q, y_d;
   logic        cmd_valid_q, cmd_valid_d, pixel_valid_q, pixel_valid_d;
   logic        frame_done_q, frame_done_d;
   logic [7:0]  cmd_code_q, cmd_code_d, pixel_x_q, pixel_x_d;
   logic [8:0]  pixel_y_q, pixel_y_d;
   logic [15:0] pixel_data_q, pixel_data_d;

   logic        wr_evt;
   logic [15:0] arg_start, arg_end;
   logic [7:0]  col_s, col_e;
   logic [8:0]  page_s, page_e;

   always_comb begin
      bus_r1_d = '{wr_n: LT24Wr_n, rd_n: LT24Rd_n, cs_n: LT24CS_n, rs: LT24RS,
                   reset_n: LT24Reset_n, lcd_on: LT24LCDOn, data: LT24Data};
      bus_r2_d = bus_r1_q;

      // Rising Wr_n seen between the two stages marks the end of a write strobe.
      wr_evt = !bus_r2_q.wr_n && bus_r1_q.wr_n && !bus_r2_q.cs_n && bus_r2_q.rd_n;

      arg_start = {start_hi_q, start_lo_q};
      arg_end   = {end_hi_q, bus_r2_q.data[7:0]};
      col_s  = (arg_start > X_LIM16) ? X_MAX : arg_start[7:0];
      col_e  = (arg_end   > X_LIM16) ? X_MAX : arg_end[7:0];
      page_s = (arg_start > Y_LIM16) ? Y_MAX : arg_start[8:0];
      page_e = (arg_end   > Y_LIM16) ? Y_MAX : arg_end[8:0];
      if (col_s > col_e)   col_e  = col_s;
      if (page_s > page_e) page_e = page_s;

      state_d       = state_q;
      cnt_d         = cnt_q;
      start_hi_d    = start_hi_q;
      start_lo_d    = start_lo_q;
      end_hi_d      = end_hi_q;
      x_start_d     = x_start_q;
      x_end_d       = x_end_q;
      y_start_d     = y_start_q;
      y_end_d       = y_end_q;
      x_d           = x_q;
      y_d           = y_q;
      cmd_valid_d   = 1'b0;
      pixel_valid_d = 1'b0;
      frame_done_d  = 1'b0;
      cmd_code_d    = cmd_code_q;
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      pixel_data_d  = pixel_data_q;

      if (!bus_r2_q.reset_n) begin
         state_d   = IDLE;
         cnt_d     = 2'd0;
         x_start_d = 8'd0;
         x_end_d   = X_MAX;
         y_start_d = 9'd0;
         y_end_d   = Y_MAX;
         x_d       = 8'd0;
         y_d       = 9'd0;
      end else if (wr_evt && !bus_r2_q.rs) begin
         cmd_valid_d = 1'b1;
         cmd_code_d  = bus_r2_q.data[7:0];
         cnt_d       = 2'd0;
         case (bus_r2_q.data[7:0])
            8'h2A:   state_d = COL_ARGS;
            8'h2B:   state_d = PAGE_ARGS;
            8'h2C: begin
               state_d = MEM_WRITE;
               x_d     = x_start_q;
               y_d     = y_start_q;
            end
            default: state_d = IGNORE;
         endcase
      end else if (wr_evt) begin
         case (state_q)
            COL_ARGS, PAGE_ARGS: begin
               cnt_d = cnt_q + 2'd1;
               case (cnt_q)
                  2'd0: start_hi_d = bus_r2_q.data[7:0];
                  2'd1: start_lo_d = bus_r2_q.data[7:0];
                  2'd2: end_hi_d   = bus_r2_q.data[7:0];
                  default: begin
                     state_d = IGNORE;
                     if (state_q == COL_ARGS) begin
                        x_start_d = col_s;
                        x_end_d   = col_e;
                     end else begin
                        y_start_d = page_s;
                        y_end_d   = page_e;
                     end
                  end
               endcase
            end
            MEM_WRITE: begin
               pixel_valid_d = 1'b1;
               pixel_x_d     = x_q;
               pixel_y_d     = y_q;
               pixel_data_d  = bus_r2_q.data;
               if (x_q < x_end_q) begin
                  x_d = x_q + 8'd1;
               end else begin
                  x_d = x_start_q;
                  if (y_q < y_end_q) begin
                     y_d = y_q + 9'd1;
                  end else begin
                     y_d          = y_start_q;
                     frame_done_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         bus_r1_q      <= BUS_RST;
         bus_r2_q      <= BUS_RST;
         cnt_q         <= 2'd0;
         start_hi_q    <= 8'd0;
         start_lo_q    <= 8'd0;
         end_hi_q      <= 8'd0;
         x_start_q     <= 8'd0;
         x_end_q       <= X_MAX;
         y_start_q     <= 9'd0;
         y_end_q       <= Y_MAX;
         x_q           <= 8'd0;
         y_q           <= 9'd0;
         cmd_valid_q   <= 1'b0;
         pixel_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         cmd_code_q    <= 8'd0;
         pixel_x_q     <= 8'd0;
         pixel_y_q     <= 9'd0;
         pixel_data_q  <= 16'd0;
      end else begin
         state_q       <= state_d;
         bus_r1_q      <= bus_r1_d;
         bus_r2_q      <= bus_r2_d;
         cnt_q         <= cnt_d;
         start_hi_q    <= start_hi_d;
         start_lo_q    <= start_lo_d;
         end_hi_q      <= end_hi_d;
         x_start_q     <= x_start_d;
         x_end_q       <= x_end_d;
         y_start_q     <= y_start_d;
         y_end_q       <= y_end_d;
         x_q           <= x_d;
         y_q           <= y_d;
         cmd_valid_q   <= cmd_valid_d;
         pixel_valid_q <= pixel_valid_d;
         frame_done_q  <= frame_done_d;
         cmd_code_q    <= cmd_code_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         pixel_data_q  <= pixel_data_d;
      end
   end

   assign cmdValid   = cmd_valid_q;
   assign cmdCode    = cmd_code_q;
   assign pixelValid = pixel_valid_q;
   assign pixelX     = pixel_x_q;
   assign pixelY     = pixel_y_q;
   assign pixelData  = pixel_data_q;
   assign frameDone  = frame_done_q;
   assign lcdOn      = bus_r2_q.lcd_on;

endmodule

// File: tb/tb_lt24_bus_decoder.sv
// Directed bench for lt24_bus_decoder: bus writes are driven on falling edges,
// results sampled 1ns after rising edges and compared against hand-computed values.
module tb_lt24_bus_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn;
   logic [15:0] LT24Data;
   logic        cmdValid, pixelValid, frameDone, lcdOn;
   logic [7:0]  cmdCode, pixelX;
   logic [8:0]  pixelY;
   logic [15:0] pixelData;

   int vectors = 0;
   int miscompares = 0;
   int cmd_pulses = 0;
   int pix_pulses = 0;

   logic        e_cmd, e_pix, s_cmd, s_pix, s_fd, a_cmd, a_pix;
   logic [7:0]  s_code, s_px;
   logic [8:0]  s_py;
   logic [15:0] s_pd;

   lt24_bus_decoder #(.WIDTH(240), .HEIGHT(320)) dut (
      .clock(clk), .reset(reset),
      .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n), .LT24CS_n(LT24CS_n),
      .LT24RS(LT24RS), .LT24Reset_n(LT24Reset_n), .LT24LCDOn(LT24LCDOn),
      .LT24Data(LT24Data),
      .cmdValid(cmdValid), .cmdCode(cmdCode), .pixelValid(pixelValid),
      .pixelX(pixelX), .pixelY(pixelY), .pixelData(pixelData),
      .frameDone(frameDone), .lcdOn(lcdOn)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pixelValid) pix_pulses++;
      if (cmdValid)   cmd_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One write strobe; samples half a cycle early, on the pulse cycle, and one cycle later.
   task automatic bus_wr(input logic rs, input logic [15:0] d, input logic cs, input logic rd);
      @(negedge clk);
      LT24CS_n = cs; LT24RS = rs; LT24Data = d; LT24Rd_n = rd; LT24Wr_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      LT24Wr_n = 1'b1;
      @(posedge clk); #1;
      e_cmd = cmdValid; e_pix = pixelValid;
      @(posedge clk); #1;
      s_cmd = cmdValid; s_code = cmdCode; s_pix = pixelValid;
      s_px = pixelX; s_py = pixelY; s_pd = pixelData; s_fd = frameDone;
      @(posedge clk); #1;
      a_cmd = cmdValid; a_pix = pixelValid;
      @(negedge clk);
      LT24CS_n = 1'b1; LT24Rd_n = 1'b1;
   endtask

   task automatic wr_cmd(input logic [7:0] c);
      bus_wr(1'b0, {8'h00, c}, 1'b0, 1'b1);
   endtask

   task automatic wr_dat(input logic [15:0] d);
      bus_wr(1'b1, d, 1'b0, 1'b1);
   endtask

   task automatic wr_args(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
      wr_dat({8'h00, b0}); wr_dat({8'h00, b1}); wr_dat({8'h00, b2}); wr_dat({8'h00, b3});
   endtask

   initial begin
      int n_pix, n_cmd;
      int exp_x [7];
      int exp_y [7];
      exp_x = '{10, 11, 12, 10, 11, 12, 10};
      exp_y = '{20, 20, 20, 21, 21, 21, 20};

      reset = 1'b0;
      LT24Wr_n = 1'b1; LT24Rd_n = 1'b1; LT24CS_n = 1'b1; LT24RS = 1'b0;
      LT24Reset_n = 1'b1; LT24LCDOn = 1'b1; LT24Data = 16'h0000;

      // Bus activity while in reset must leave no trace afterwards.
      repeat (2) @(negedge clk);
      LT24CS_n = 1'b0; LT24Wr_n = 1'b0; LT24Data = 16'h002C;
      repeat (2) @(negedge clk);
      LT24Wr_n = 1'b1; LT24CS_n = 1'b1;
      @(posedge clk); #1;
      check("rst_cmdValid", cmdValid, 0);
      check("rst_cmdCode", cmdCode, 0);
      check("rst_pixelValid", pixelValid, 0);
      check("rst_pixelX", pixelX, 0);
      check("rst_pixelY", pixelY, 0);
      check("rst_pixelData", pixelData, 0);
      check("rst_frameDone", frameDone, 0);
      check("rst_lcdOn", lcdOn, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(posedge clk); #1;
      check("post_rst_no_cmd", cmd_pulses, 0);
      check("post_rst_no_pix", pix_pulses, 0);
      check("lcdOn_hi", lcdOn, 1);
      @(negedge clk);
      LT24LCDOn = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("lcdOn_lo", lcdOn, 0);
      @(negedge clk);
      LT24LCDOn = 1'b1;

      // Window 10..12 x 20..21 then seven pixels.
      wr_cmd(8'h2A);
      check("cmd2A_early", e_cmd, 0);
      check("cmd2A_valid", s_cmd, 1);
      check("cmd2A_code", s_code, 8'h2A);
      check("cmd2A_width", a_cmd, 0);
      wr_args(8'h00, 8'h0A, 8'h00, 8'h0C);
      wr_cmd(8'h2B);
      check("cmd2B_code", s_code, 8'h2B);
      wr_args(8'h00, 8'h14, 8'h00, 8'h15);
      wr_cmd(8'h2C);
      check("cmd2C_code", s_code, 8'h2C);
      for (int i = 0; i < 7; i++) begin
         wr_dat(16'(16'h1111 * (i + 1)));
         check("win_valid", s_pix, 1);
         check("win_x", s_px, exp_x[i]);
         check("win_y", s_py, exp_y[i]);
         check("win_data", s_pd, 16'h1111 * (i + 1));
         check("win_frameDone", s_fd, (i == 5) ? 1 : 0);
         check("win_pulse_width", a_pix, 0);
      end
      check("code_held", cmdCode, 8'h2C);

      // Hard reset in the middle of MEM_WRITE.
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("mid_rst_cmdCode", cmdCode, 0);
      check("mid_rst_pixelX", pixelX, 0);
      check("mid_rst_pixelY", pixelY, 0);
      check("mid_rst_pixelData", pixelData, 0);
      check("mid_rst_frameDone", frameDone, 0);
      check("mid_rst_pixelValid", pixelValid, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      n_pix = pix_pulses;
      wr_dat(16'hABCD);
      check("idle_drop", pix_pulses, n_pix);
      wr_cmd(8'h2C);
      wr_dat(16'h1234);
      check("mid_rst_px", s_px, 0);
      check("mid_rst_py", s_py, 0);
      check("mid_rst_pd", s_pd, 16'h1234);

      // Default window row wrap.
      wr_cmd(8'h2C);
      for (int i = 0; i < 241; i++) begin
         wr_dat(16'(i));
         check("dflt_x", s_px, (i < 240) ? i : 0);
         check("dflt_y", s_py, (i < 240) ? 0 : 1);
      end

      // Partial column args are discarded; CS_n high and reads are ignored.
      wr_cmd(8'h2A);
      wr_dat(16'h0000);
      wr_dat(16'h0005);
      wr_cmd(8'h2C);
      wr_dat(16'h5555);
      check("partial_x", s_px, 0);
      check("partial_y", s_py, 0);
      n_pix = pix_pulses;
      n_cmd = cmd_pulses;
      bus_wr(1'b1, 16'h6666, 1'b1, 1'b1);
      bus_wr(1'b0, 16'h002A, 1'b1, 1'b1);
      bus_wr(1'b1, 16'h7777, 1'b0, 1'b0);
      check("cs_hi_no_pix", pix_pulses, n_pix);
      check("cs_hi_no_cmd", cmd_pulses, n_cmd);
      wr_dat(16'h8888);
      check("after_ignored_x", s_px, 1);

      // Column args beyond the display clamp to the last column.
      wr_cmd(8'h2A);
      wr_args(8'h01, 8'h00, 8'h00, 8'hF0);
      wr_cmd(8'h2C);
      for (int i = 0; i < 3; i++) begin
         wr_dat(16'hC000 + 16'(i));
         check("clamp_x", s_px, 239);
         check("clamp_y", s_py, i);
         check("clamp_fd", s_fd, 0);
      end

      // LT24Reset_n low mid-stream.
      wr_cmd(8'h2A);
      wr_args(8'h00, 8'h0A, 8'h00, 8'h0C);
      wr_cmd(8'h2C);
      wr_dat(16'h0101);
      check("lrst_pre_x", s_px, 10);
      @(negedge clk);
      LT24Reset_n = 1'b0;
      repeat (3) @(posedge clk);
      n_pix = pix_pulses;
      n_cmd = cmd_pulses;
      wr_dat(16'h0202);
      wr_cmd(8'h2B);
      wr_dat(16'h0303);
      check("lrst_no_pix", pix_pulses, n_pix);
      check("lrst_no_cmd", cmd_pulses, n_cmd);
      @(negedge clk);
      LT24Reset_n = 1'b1;
      repeat (3) @(posedge clk);
      wr_cmd(8'h2C);
      check("lrst_cmd_early", e_cmd, 0);
      check("lrst_cmd_valid", s_cmd, 1);
      check("lrst_cmd_code", s_code, 8'h2C);
      wr_dat(16'h0404);
      check("lrst_px", s_px, 0);
      check("lrst_py", s_py, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lt24_bus_decoder.md
LT24_BUS_DECODER -- requirements
Module: lt24_bus_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 240, display width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 320, display height in pixels.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have inputs LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn  input  1 each  LT24 bus, same clock domain.
REQ-006 SHALL have port LT24Data  input  16  LT24 bus data.
REQ-007 SHALL have port cmdValid  output  1  one-cycle pulse per decoded command write.
REQ-008 SHALL have port cmdCode  output  8  last command byte, LT24Data[7:0].
REQ-009 SHALL have port pixelValid  output  1  one-cycle pulse per pixel write.
REQ-010 SHALL have ports pixelX  output  8, pixelY  output  9, pixelData  output  16, giving the coordinate and colour of the pulsed pixel.
REQ-011 SHALL have port frameDone  output  1  one-cycle pulse with the last pixel of the window.
REQ-012 SHALL have port lcdOn  output  1  registered copy of LT24LCDOn.

Function
REQ-013 SHALL register all bus inputs through two stages, r1 then r2.
REQ-014 SHALL detect a write event when r2.Wr_n=0, r1.Wr_n=1, r2.CS_n=0, and r2.Rd_n=1, and SHALL take RS and Data from r2.
REQ-015 SHALL assert cmdValid/pixelValid on the clock edge following the edge at which r1 first holds Wr_n=1, for exactly one cycle.
REQ-016 SHALL ignore all writes with CS_n high and all read strobes.
REQ-017 SHALL treat an event with RS=0 as a command and SHALL pulse cmdValid regardless of state.
REQ-018 SHALL treat an event with RS=1 as data, routed by state.
REQ-019 SHALL have FSM states IDLE, COL_ARGS, PAGE_ARGS, MEM_WRITE, and IGNORE.
REQ-020 SHALL, on any command, go to COL_ARGS for 0x2A, PAGE_ARGS for 0x2B, MEM_WRITE for 0x2C, or IGNORE for any other code, and SHALL clear the argument byte counter.
REQ-021 SHALL, in COL_ARGS and PAGE_ARGS, collect 4 data bytes (LT24Data[7:0]) as startHi, startLo, endHi, endLo, and SHALL commit the window on the 4th byte, then go to IGNORE.
REQ-022 SHALL discard a partial (fewer than 4 bytes) argument set if a command arrives, leaving the window unchanged.
REQ-023 SHALL, on commit, clamp 16-bit values above WIDTH-1 (column) or HEIGHT-1 (page) to that limit, and SHALL set end := start if start > end after clamping.
REQ-024 SHALL, on entering MEM_WRITE, load the cursor as x=xStart, y=yStart.
REQ-025 SHALL, for each data event in MEM_WRITE, output pixelX=x, pixelY=y, pixelData=Data[15:0], and then advance the cursor.
REQ-026 SHALL advance the cursor as x+1 if x<xEnd; otherwise x=xStart and y+1 if y<yEnd; otherwise x=xStart, y=yStart, with frameDone pulsed alongside that pixel.
REQ-027 SHALL discard data events in IDLE and IGNORE.
REQ-028 SHALL, while r2.Reset_n=0, force IDLE, restore the default window, clear the cursor and pulses, and ignore all events.
REQ-029 SHALL keep pixelX, pixelY, pixelData, and cmdCode holding their last values between pulses.

Reset
REQ-030 SHALL, while reset=0, clear all outputs, synchroniser stages (Wr_n, CS_n, Rd_n stages set to 1), cursor, and counter, and SHALL enter IDLE.
REQ-031 SHALL reset the window to xStart=0, xEnd=WIDTH-1, yStart=0, yEnd=HEIGHT-1.
REQ-032 SHALL have reset deassertion take effect at the first following clock edge, with no output pulse generated from pre-reset bus state.

Verification
REQ-033 SHALL verify reset mid-MEM_WRITE -> all outputs 0, FSM IDLE, and the next 0x2C plus one pixel -> pixelX=0, pixelY=0.
REQ-034 SHALL verify 0x2A args 00,0A,00,0C; 0x2B args 00,14,00,15; 0x2C; pixels 0x1111..0x7777 -> (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) with frameDone on the 6th, and the 7th at (10,20).
REQ-035 SHALL verify default window, 0x2C, 241 pixels -> x runs 0..239 at y=0, and the 241st is at (0,1).
REQ-036 SHALL verify 0x2A args 01,00,00,F0 -> start clamps to 239 and end becomes 239, so every pixel is at x=239.
REQ-037 SHALL verify 0x2A with 2 args then 0x2C -> window unchanged (pixel at x=0); writes with CS_n=1 produce no pulses.
REQ-038 SHALL verify LT24Reset_n low mid-stream -> pulses stop and the window resets, with cmdValid/cmdCode=0x2C one cycle after the Wr_n rising edge.
